az_sample_controller: RTL and testbench
=======================================

// Module: az_sample_controller
//
// PURPOSE
//  Upstream sequencer for the integrating ADC. Steps the input azmux between signal (HI) and
//  auto-zero (LO) in az mode, or holds HI in non-az mode. After each mux change and settle
//  period it pulses adc_measure_trig, then waits for the ADC's adc_measure_valid. It tags each
//  completed conversion with its phase and a running count so downstream readout can pair HI/LO.
//
// PARAMETERS
//  AZMUX_W      4          width of azmux select code
//  TIMEOUT_W    32         width of valid-wait watchdog counter
//
// PORTS
//  clk                 in   1        system clock
//  reset               in   1        asynchronous, active-high reset
//  run                 in   1        1 = sequence continuously; 0 = finish current conversion, then idle
//  az_enable           in   1        1 = alternate HI/LO phases; 0 = HI only
//  clk_settle_duration in   24       clocks to wait after a mux change before trig (0 allowed)
//  clk_timeout         in   32       max clocks to wait for adc_measure_valid
//  azmux_hi_code       in   AZMUX_W  azmux code selecting signal input
//  azmux_lo_code       in   AZMUX_W  azmux code selecting zero/lo input
//  adc_measure_valid   in   1        from ADC; low after trig, high when conversion done
//  azmux               out  AZMUX_W  analog input mux select
//  adc_measure_trig    out  1        one-cycle start pulse to ADC
//  sample_valid        out  1        one-cycle pulse: conversion complete, phase/count valid
//  sample_phase        out  1        0 = HI, 1 = LO; phase of the completed conversion
//  sample_count        out  16       completed conversions since reset; wraps 0xFFFF->0
//  timeout_err         out  1        sticky; set on watchdog expiry, cleared by reset or run rising
//  monitor             out  6        debug: [2:0] state, [3] trig, [4] valid in, [5] phase
//
// BEHAVIOUR
//  - Reset: state=IDLE, azmux=azmux_hi_code sampled as 0 (all-zero code), trig=0, sample_valid=0,
//    sample_phase=0, sample_count=0, timeout_err=0, monitor=0. All outputs registered.
//  - States: IDLE -> SETTLE -> TRIG -> ARM -> WAIT -> DONE -> (SETTLE | IDLE).
//  - IDLE: azmux holds last value. On run=1: phase<=HI, azmux<=azmux_hi_code,
//    cnt<=clk_settle_duration, go SETTLE.
//  - SETTLE: decrement cnt; at cnt==0 go TRIG (settle 0 => one cycle in SETTLE).
//  - TRIG: adc_measure_trig=1 for exactly this cycle; load watchdog<=clk_timeout; go ARM.
//  - ARM: one-cycle guard. The ADC drops valid one clock after trig, so valid is not sampled
//    here; stale high valid from the prior conversion must never complete a sample. Go WAIT.
//  - WAIT: on valid=1 go DONE. Else decrement watchdog; at 0 set timeout_err, go SETTLE
//    with same phase and reload settle, i.e. retry, with no sample_valid and no count change.
//  - DONE: sample_valid=1 one cycle, sample_phase=phase, sample_count+=1.
//    Next phase = az_enable ? ~phase : HI. Drive azmux to that phase's code, reload settle.
//    If run=0 go IDLE, else SETTLE.
//  - Mux change occurs only on entry to SETTLE, never while ADC is integrating.
//  - Codes/az_enable/durations sampled at phase boundaries (DONE/IDLE exit); mid-phase
//    changes take effect next phase.
//  - run dropping mid-conversion: current conversion completes, one sample_valid, then IDLE.
//  - run rising clears timeout_err in the same cycle IDLE exits.
//  - Reset mid-operation: immediate return to reset values; ADC may be left integrating,
//    which is harmless because the ADC is retriggerable.
//
// STRUCTURE
//  - Shared package/header: state encodings (3-bit), PHASE_HI=0/PHASE_LO=1, default azmux codes.
//  - One sub-module natural: down_counter (load, enable, zero flag), instanced for settle and
//    watchdog. Everything else is inline.
//
// TESTING  (bench includes a behavioural ADC: valid low 1 clk after trig, high N clks later)
//  1 az_enable=1, settle=10, ADC N=100, run 4 samples -> phases HI,LO,HI,LO; count 1..4; azmux
//    alternates hi/lo codes; trig exactly 11 clks after each mux change.
//  2 az_enable=0 -> every sample_phase=0, azmux constant hi code, trig period = 1+11+1+1+101.
//  3 ADC valid held high from prior conversion -> no sample_valid until fresh valid after ARM.
//  4 ADC never asserts valid, timeout=50 -> timeout_err=1 after 50 WAIT clks, retrigger, count unchanged.
//  5 run dropped during WAIT -> exactly one more sample_valid, then IDLE with no further trig.
//  6 reset asserted in WAIT, preload count 0xFFFF -> all outputs zero; separately verify wrap to 0.

Source files
------------

// File: rtl/az_sample_controller_pkg.sv
// az_sample_controller_pkg: shared types and constants for the ADC sample sequencer
package az_sample_controller_pkg;
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_TRIG   = 3'd2,
      S_ARM    = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;
   localparam logic PHASE_HI = 1'b0;
   localparam logic PHASE_LO = 1'b1;
   localparam int AZMUX_W_DEFAULT = 4;
   localparam int TIMEOUT_W_DEFAULT = 32;
   localparam logic [7:0] AZMUX_DEFAULT_CODE = 8'h00;
endpackage

// File: rtl/az_sample_controller_down_counter.sv
// az_sample_controller_down_counter: loadable down counter that stops at zero
//   clk, reset        clock, async active-high reset
//   load, load_val    load has priority over en
//   en                decrement while nonzero
//   zero              count is zero
module az_sample_controller_down_counter
   import az_sample_controller_pkg::*;
#(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = cnt == '0;
endmodule

// File: rtl/az_sample_controller.sv
// az_sample_controller: steps azmux HI/LO, triggers the ADC, tags completed conversions
//   run, az_enable                   sequencing control
//   clk_settle_duration, clk_timeout settle delay and valid-wait watchdog
//   azmux_hi_code, azmux_lo_code     mux codes for signal / zero input
//   adc_measure_valid                ADC conversion-done level
//   azmux, adc_measure_trig          mux select, one-cycle ADC start
//   sample_valid/phase/count         completed-conversion tag
//   timeout_err, monitor             sticky watchdog flag, debug view
module az_sample_controller
   import az_sample_controller_pkg::*;
#(
   parameter int AZMUX_W   = AZMUX_W_DEFAULT,
   parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 az_enable,
   input  logic [23:0]          clk_settle_duration,
   input  logic [TIMEOUT_W-1:0] clk_timeout,
   input  logic [AZMUX_W-1:0]   azmux_hi_code,
   input  logic [AZMUX_W-1:0]   azmux_lo_code,
   input  logic                 adc_measure_valid,
   output logic [AZMUX_W-1:0]   azmux,
   output logic                 adc_measure_trig,
   output logic                 sample_valid,
   output logic                 sample_phase,
   output logic [15:0]          sample_count,
   output logic                 timeout_err,
   output logic [5:0]           monitor
);
   state_t state, next_state;
   logic phase, phase_ld, phase_nx, run_q, timeout_hit, settle_zero, wd_zero;
   logic [TIMEOUT_W-1:0] wd_val;

   az_sample_controller_down_counter #(.W(24)) u_settle (
      .clk(clk), .reset(reset), .load(phase_ld | timeout_hit), .en(state == S_SETTLE),
      .load_val(clk_settle_duration), .zero(settle_zero)
   );

   az_sample_controller_down_counter #(.W(TIMEOUT_W)) u_watchdog (
      .clk(clk), .reset(reset), .load(state == S_TRIG), .en(state == S_WAIT),
      .load_val(wd_val), .zero(wd_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else state <= next_state;
   end

   // ARM never looks at valid: the ADC may still show the previous conversion's valid there
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   next_state = run ? S_SETTLE : S_IDLE;
         S_SETTLE: next_state = settle_zero ? S_TRIG : S_SETTLE;
         S_TRIG:   next_state = S_ARM;
         S_ARM:    next_state = S_WAIT;
         S_WAIT:   next_state = adc_measure_valid ? S_DONE : wd_zero ? S_SETTLE : S_WAIT;
         S_DONE:   next_state = run ? S_SETTLE : S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // watchdog loads timeout-1 and expires on zero, giving exactly clk_timeout WAIT clocks
   always_comb begin
      timeout_hit = state == S_WAIT && !adc_measure_valid && wd_zero;
      phase_ld    = (state == S_IDLE && run) || state == S_DONE;
      phase_nx    = (state == S_DONE && az_enable) ? ~phase : PHASE_HI;
      wd_val      = clk_timeout == '0 ? '0 : clk_timeout - 1'b1;
   end

   // registered outputs are computed from next_state so they line up with the state itself
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase            <= PHASE_HI;
         azmux            <= AZMUX_W'(AZMUX_DEFAULT_CODE);
         run_q            <= 1'b0;
         adc_measure_trig <= 1'b0;
         sample_valid     <= 1'b0;
         sample_phase     <= PHASE_HI;
         sample_count     <= '0;
         timeout_err      <= 1'b0;
         monitor          <= '0;
      end else begin
         run_q            <= run;
         adc_measure_trig <= next_state == S_TRIG;
         sample_valid     <= next_state == S_DONE;
         timeout_err      <= timeout_hit | (timeout_err & ~(run & ~run_q));
         monitor          <= {phase_ld ? phase_nx : phase, adc_measure_valid, next_state == S_TRIG, next_state};
         if (phase_ld) begin
            phase <= phase_nx;
            azmux <= phase_nx == PHASE_LO ? azmux_lo_code : azmux_hi_code;
         end
         if (next_state == S_DONE) begin
            sample_phase <= phase;
            sample_count <= sample_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_az_sample_controller.sv
// tb_az_sample_controller: directed bench with behavioural ADC for az_sample_controller
module tb_az_sample_controller;
   import az_sample_controller_pkg::*;

   typedef struct {
      logic       az;
      int         settle;
      int         n;
      int         ns;
      logic [3:0] hi;
      logic [3:0] lo;
      int         exp_lat;
      int         exp_period;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        az_enable = 1'b0;
   logic [23:0] clk_settle_duration = '0;
   logic [31:0] clk_timeout = 32'd1000;
   logic [3:0]  azmux_hi_code = 4'h0;
   logic [3:0]  azmux_lo_code = 4'h0;
   logic        adc_measure_valid = 1'b1;
   logic [3:0]  azmux;
   logic        adc_measure_trig, sample_valid, sample_phase, timeout_err;
   logic [15:0] sample_count;
   logic [5:0]  monitor;
   logic [2:0]  mon_state;

   int total = 0, bad = 0, cyc = 0, sv_seen = 0, trig_seen = 0;
   int adc_n = 10, adc_cnt = 0;
   logic adc_late = 1'b0, adc_dead = 1'b0;
   int exp_count = 0;
   vec_t vecs[4];

   az_sample_controller dut (
      .clk(clk), .reset(reset), .run(run), .az_enable(az_enable),
      .clk_settle_duration(clk_settle_duration), .clk_timeout(clk_timeout),
      .azmux_hi_code(azmux_hi_code), .azmux_lo_code(azmux_lo_code),
      .adc_measure_valid(adc_measure_valid), .azmux(azmux), .adc_measure_trig(adc_measure_trig),
      .sample_valid(sample_valid), .sample_phase(sample_phase), .sample_count(sample_count),
      .timeout_err(timeout_err), .monitor(monitor)
   );

   assign mon_state = monitor[2:0];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (sample_valid) sv_seen <= sv_seen + 1;
      if (adc_measure_trig) trig_seen <= trig_seen + 1;
   end

   // behavioural ADC: valid drops after trig (one clock later if adc_late), rises after the
   // conversion so that WAIT lasts adc_n+1 clocks
   always @(posedge clk) begin
      if (adc_measure_trig) begin
         adc_cnt <= adc_n + 1;
         if (!adc_late) adc_measure_valid <= 1'b0;
      end else if (adc_cnt != 0) begin
         adc_cnt <= adc_cnt - 1;
         if (adc_late && adc_cnt == adc_n + 1) adc_measure_valid <= 1'b0;
         if (adc_cnt == 1 && !adc_dead) adc_measure_valid <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_mon(input logic [2:0] st, input int lim, input string nm);
      int i = 0;
      while (mon_state != st && i < lim) begin
         @(negedge clk);
         i++;
      end
      if (mon_state != st) begin
         total++;
         bad++;
         $display("FAIL %s: state %0d after %0d clocks, wanted %0d", nm, mon_state, lim, st);
      end
   endtask

   task automatic wait_sig(input int sel, input int lim, input string nm);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!(sel == 0 ? adc_measure_trig : sample_valid) && i < lim);
      if (!(sel == 0 ? adc_measure_trig : sample_valid)) begin
         total++;
         bad++;
         $display("FAIL %s: no pulse within %0d clocks", nm, lim);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int t_set, t_trig, t_prev = 0;
      logic ph = PHASE_HI;
      az_enable = v.az;
      clk_settle_duration = 24'(v.settle);
      adc_n = v.n;
      azmux_hi_code = v.hi;
      azmux_lo_code = v.lo;
      run = 1'b1;
      for (int s = 0; s < v.ns; s++) begin
         wait_mon(S_SETTLE, 400, "settle_entry");
         t_set = cyc;
         wait_sig(0, 400, "trig");
         t_trig = cyc;
         chk("trig_latency", t_trig - t_set, v.exp_lat);
         chk("azmux_at_trig", azmux, ph ? v.lo : v.hi);
         if (s > 0) chk("trig_period", t_trig - t_prev, v.exp_period);
         t_prev = t_trig;
         if (s == v.ns - 1) run = 1'b0;
         wait_sig(1, 400, "sample_valid");
         exp_count++;
         chk("sample_phase", sample_phase, ph);
         chk("sample_count", sample_count, exp_count);
         ph = v.az ? ~ph : PHASE_HI;
      end
      wait_mon(S_IDLE, 50, "vec_idle");
   endtask

   initial begin
      int t0, w, sv0, tr0;
      vecs[0] = '{1'b1, 10, 100, 4, 4'h3, 4'hC, 11, 115};
      vecs[1] = '{1'b0, 10, 100, 3, 4'h3, 4'hC, 11, 115};
      vecs[2] = '{1'b1, 0, 5, 4, 4'h6, 4'h9, 1, 10};
      vecs[3] = '{1'b0, 3, 20, 3, 4'hA, 4'h5, 4, 28};

      repeat (3) @(negedge clk);
      chk("rst_azmux", azmux, 0);
      chk("rst_trig", adc_measure_trig, 0);
      chk("rst_sv", sample_valid, 0);
      chk("rst_count", sample_count, 0);
      chk("rst_monitor", monitor, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 4; k++) run_vec(vecs[k]);

      // stale valid still high during ARM must not complete the sample
      adc_late = 1'b1;
      adc_n = 10;
      clk_settle_duration = 24'd2;
      run = 1'b1;
      wait_sig(0, 100, "stale_trig");
      t0 = cyc;
      run = 1'b0;
      wait_sig(1, 100, "stale_sv");
      exp_count++;
      chk("stale_trig_to_sv", cyc - t0, 13);
      chk("stale_count", sample_count, exp_count);
      wait_mon(S_IDLE, 50, "stale_idle");
      adc_late = 1'b0;

      // watchdog expiry and retry
      adc_dead = 1'b1;
      clk_timeout = 32'd50;
      sv0 = sv_seen;
      run = 1'b1;
      wait_sig(0, 100, "to_trig");
      w = 0;
      for (int i = 0; i < 300 && !timeout_err; i++) begin
         @(negedge clk);
         if (mon_state == S_WAIT) w++;
      end
      chk("to_wait_clks", w, 50);
      chk("to_err", timeout_err, 1);
      chk("to_retry_state", mon_state, S_SETTLE);
      chk("to_count", sample_count, exp_count);
      wait_sig(0, 100, "to_retrig");
      chk("to_no_sv", sv_seen - sv0, 0);
      adc_dead = 1'b0;
      run = 1'b0;
      wait_sig(1, 200, "to_sv");
      exp_count++;
      chk("to_after_count", sample_count, exp_count);
      chk("to_sticky", timeout_err, 1);
      wait_mon(S_IDLE, 50, "to_idle");
      clk_timeout = 32'd1000;

      // run dropped during WAIT: one more sample then idle, timeout cleared on run rising
      adc_n = 30;
      run = 1'b1;
      @(negedge clk);
      chk("to_cleared", timeout_err, 0);
      wait_mon(S_WAIT, 100, "drop_wait");
      sv0 = sv_seen;
      tr0 = trig_seen;
      run = 1'b0;
      wait_mon(S_IDLE, 200, "drop_idle");
      repeat (100) @(negedge clk);
      exp_count++;
      chk("drop_sv_once", sv_seen - sv0, 1);
      chk("drop_no_trig", trig_seen - tr0, 0);
      chk("drop_state", mon_state, S_IDLE);
      chk("drop_count", sample_count, exp_count);

      // async reset in WAIT
      azmux_hi_code = 4'h5;
      run = 1'b1;
      wait_mon(S_WAIT, 100, "rst_wait");
      chk("pre_rst_azmux", azmux, 4'h5);
      reset = 1'b1;
      #1;
      chk("mid_rst_azmux", azmux, 0);
      chk("mid_rst_count", sample_count, 0);
      chk("mid_rst_monitor", monitor, 0);
      chk("mid_rst_trig_sv_ph_to", {adc_measure_trig, sample_valid, sample_phase, timeout_err}, 0);
      run = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // count wrap 0xFFFF -> 0
      force dut.sample_count = 16'hFFFF;
      @(negedge clk);
      release dut.sample_count;
      run = 1'b1;
      wait_sig(0, 100, "wrap_trig");
      run = 1'b0;
      wait_sig(1, 100, "wrap_sv");
      chk("wrap_count", sample_count, 0);
      wait_mon(S_IDLE, 50, "wrap_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
